// File: rtl/fma16_vec_checker.sv
// Stimulus/check initiator for fma16: streams 80-bit vectors from a synchronous ROM,
// drives the operands and controls, and compares result/flags against the expected fields.
module fma16_vec_checker #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned CHECK_FLAGS = 1,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_vecs,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [79:0]       vec_data,
  output logic [15:0]       x,
  output logic [15:0]       y,
  output logic [15:0]       z,
  output logic              mul,
  output logic              add,
  output logic              negp,
  output logic              negz,
  output logic [1:0]        roundmode,
  input  logic [15:0]       fma_result,
  input  logic [3:0]        fma_flags,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] nv;
  logic [15:0]       rexp;
  logic [3:0]        fexp;
  logic              accept;
  logic              last_vec;
  logic              rexp_nan;
  logic              res_nan;
  logic              res_bad;
  logic              flag_bad;
  logic              mismatch;
  logic              unused_bits;

  assign unused_bits = &{1'b0, vec_data[31:30], vec_data[7:4]};

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_vec = (idx == nv - ADDR_W'(1));

  // An expected NaN matches any NaN payload the datapath produces.
  assign rexp_nan = (rexp[14:10] == 5'h1F) && (rexp[9:0] != 10'd0);
  assign res_nan  = (fma_result[14:10] == 5'h1F) && (fma_result[9:0] != 10'd0);
  assign res_bad  = rexp_nan ? !res_nan : (fma_result != rexp);
  assign flag_bad = (CHECK_FLAGS != 0) && (fma_flags != fexp);
  assign mismatch = res_bad || flag_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_rd    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (num_vecs == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        vec_rd    = 1'b1;
        busy      = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (last_vec || (mismatch && (STOP_ON_ERR != 0))) state_nxt = S_DONE;
        else                                              state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign vec_addr = idx;
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx             <= '0;
      nv              <= '0;
      x               <= '0;
      y               <= '0;
      z               <= '0;
      mul             <= 1'b0;
      add             <= 1'b0;
      negp            <= 1'b0;
      negz            <= 1'b0;
      roundmode       <= '0;
      rexp            <= '0;
      fexp            <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      done            <= 1'b0;
    end else begin
      if (accept) begin
        idx             <= '0;
        nv              <= num_vecs;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
        done            <= (num_vecs == '0);
      end
      if (state == S_LOAD) begin
        x         <= vec_data[79:64];
        y         <= vec_data[63:48];
        z         <= vec_data[47:32];
        mul       <= vec_data[29];
        add       <= vec_data[28];
        negp      <= vec_data[27];
        negz      <= vec_data[26];
        roundmode <= vec_data[25:24];
        rexp      <= vec_data[23:8];
        fexp      <= vec_data[3:0];
      end
      if (state == S_CHECK) begin
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= idx;
          end
        end
        // idx is frozen on the final vector so it never wraps past num_vecs-1.
        if (state_nxt == S_DONE) done <= 1'b1;
        else                     idx  <= idx + ADDR_W'(1);
      end
    end
  end

endmodule
